skeleton_cpu: RTL and testbench
===============================

Name: skeleton_cpu

Overview:
- Top-level wrapper for a 32-bit single-cycle teaching CPU.
- Contains the clock divider, a 4096x32 instruction ROM, a 4096x32 data RAM, a 32x32 register file and the processor datapath/control.
- Exports its derived clocks so a bench can sample on them, and keeps the internal nets ctrl_writeEnable, ctrl_writeReg[4:0], data_writeReg[31:0], wren, address_dmem[11:0], data[31:0], q_dmem[31:0] and address_imem[11:0] under exactly these names for hierarchical probing.

Parameters:
- IMEM_INIT_FILE, "imem.hex": $readmemh image loaded into the instruction ROM.
- DMEM_INIT_FILE, "dmem.hex": $readmemh image loaded into the data RAM.
- ADDR_WIDTH, 12: word-address width of both memories and of the PC.

Ports:
- clock  input  1  master clock.
- reset  input  1  asynchronous, active-low reset.
- imem_clock  output  1  ROM clock; equals clock.
- dmem_clock  output  1  RAM clock; equals clock.
- processor_clock  output  1  clock/4; the PC updates on its rising edge.
- regfile_clock  output  1  identical to processor_clock; register writes happen on its rising edge.

Behaviour:
- Clock divider: a 2-bit counter on the rising edge of clock. processor_clock = regfile_clock = counter[1], so one instruction takes 4 clock periods.
- While reset=0 (asserted): counter=0, PC=0, all 32 registers=0, derived divided clocks low. Memory contents are not cleared.
- PC (12 bit):
  - Updates on the rising edge of processor_clock to PC+1 and wraps 4095→0.
  - address_imem = PC.
  - No branches or jumps.
- ROM: synchronous read on imem_clock, so the instruction is valid 1 clock after the PC changes.
- RAM:
  - Synchronous on dmem_clock: it writes data at address_dmem when wren=1, otherwise q_dmem registers mem[address_dmem].
  - The read is valid 2 clocks after the PC changes, before the next regfile_clock edge.
- Instruction format:
  - opcode[31:27], rd[26:22], rs[21:17].
  - R-type: rt[16:12], shamt[11:7], aluop[6:2].
  - I-type: imm[16:0], sign-extended to 32 bits.
- Opcodes:
  - 00000 R-type.
  - 00101 addi: rd=rs+imm.
  - 00111 sw: mem[rs+imm]=rd.
  - 01000 lw: rd=mem[rs+imm].
  - Any other opcode is a NOP.
- ALU ops (aluop):
  - 00000 add, 00001 sub, 00010 and, 00011 or.
  - 00100 sll rs by shamt; 00101 sra rs by shamt (arithmetic).
  - Any other aluop writes 0.
- Address: address_dmem = (rs+imm)[11:0]. data = value of register rd. wren=1 only for sw.
- Writeback:
  - ctrl_writeEnable=1 for R-type, addi and lw.
  - data_writeReg is the ALU result, or q_dmem for lw.
  - Writes to r0 are ignored; r0 always reads 0.
- Register file: 2 asynchronous read ports, 1 write port. A value written in one cycle is readable in the next instruction.
- Arithmetic: 32-bit two's complement, wrap-around.
- Overflow:
  - Signed overflow on add, addi or sub is detected from operand and result signs.
  - Shifts by 0 and by 31 must be exact.

Optional Feature:
- Macro OVERFLOW_STATUS_EN.
- Defined: on overflow the write of rd is suppressed, and instead r30 is written with 1 (add), 2 (addi) or 3 (sub).
- Undefined: overflow is ignored; rd receives the wrapped result and r30 is never written implicitly.

Test Plan:
- Core sequence:
  - Program:
    - addi r1,r0,65535 (imm sign-extends to 65535 as 17-bit).
    - sll r2,r1,15.
    - addi r3,r2,32767.
    - addi r4,r0,1.
    - add r6,r1,r4.
    - sll r7,r4,31.
    - sub r9,r1,r4.
    - and r10,r1,r2.
    - or r12,r1,r2.
  - Required: r1=0x0000FFFF, r2=0x7FFF8000, r3=0x7FFFFFFF, r4=1, r6=0x10000, r7=0x80000000, r9=0xFFFE, r10=0x8000, r12=0x7FFFFFFF, r30=0.
- Back-to-back dependencies:
  - Program: r20=2, r21=r4+r20, r22=r20-r4, r23=r22&r21, r24=r20|r23, r25=r23<<1, r26=r25>>>1.
  - Required: 2, 3, 1, 1, 3, 2, 1.
- Memory:
  - DMEM image has mem[1]=1 and mem[2]=2. Program: r27=456; sw r1,0(r27); lw r28,1(r0); lw r29,2(r0); lw r19,0(r27).
  - Required: r28=1, r29=2, r19=65535, and wren high exactly one processor cycle.
- Overflow:
  - Program: add r5,r3,r4, with 0x7FFFFFFF+1.
  - With OVERFLOW_STATUS_EN: r30=1 and r5 unchanged.
  - Without it: r5=0x80000000 and r30 unchanged.
- r0 and reset:
  - addi r0,r0,5 → r0 reads 0.
  - Assert reset mid-program → PC=0 and all registers=0 immediately. On release, execution restarts from address 0.

Source files
------------

// File: rtl/skeleton_cpu.sv
// skeleton_cpu: 32-bit single-cycle teaching CPU with a clock/4 divider, instruction ROM, data RAM and register file.
// Optional feature macro OVERFLOW_STATUS_EN: signed overflow on add/addi/sub writes a code to r30 instead of rd.
module skeleton_cpu #(
  parameter string IMEM_INIT_FILE = "imem.hex",
  parameter string DMEM_INIT_FILE = "dmem.hex",
  parameter int    ADDR_WIDTH     = 12
) (
  input  logic clock,
  input  logic reset,
  output logic imem_clock,
  output logic dmem_clock,
  output logic processor_clock,
  output logic regfile_clock
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_SLL = 5'b00100;
  localparam logic [4:0] ALU_SRA = 5'b00101;

  logic [1:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;

  logic [31:0] imem_mem [DEPTH];
  logic [31:0] dmem_mem [DEPTH];
  logic [31:0] regs_q   [32];
  logic [31:0] instr_q;

  logic                  ctrl_writeEnable;
  logic [4:0]            ctrl_writeReg;
  logic [31:0]           data_writeReg;
  logic                  wren;
  logic [ADDR_WIDTH-1:0] address_dmem;
  logic [ADDR_WIDTH-1:0] address_imem;
  logic [31:0]           data;
  logic [31:0]           q_dmem;

  logic [4:0]  opcode, rd, rs, rt, shamt, aluop;
  logic [4:0]  ctrl_readRegA, ctrl_readRegB;
  logic [31:0] imm_ext, reg_a, reg_b, alu_b, sum, diff, alu_result;
  logic        is_r, is_addi, is_sw, is_lw;
  logic        unused_instr_bits;

  // Clock divider: one instruction per four master clocks.
  assign cnt_d           = cnt_q + 2'd1;
  assign imem_clock      = clock;
  assign dmem_clock      = clock;
  assign processor_clock = cnt_q[1];
  assign regfile_clock   = cnt_q[1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= 2'd0;
    else        cnt_q <= cnt_d;
  end

  assign pc_d         = pc_q + ADDR_WIDTH'(1);
  assign address_imem = pc_q;

  always_ff @(posedge processor_clock or negedge reset) begin
    if (!reset) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  // ROM output register is cleared on reset so no stale store fires after release.
  always_ff @(posedge imem_clock or negedge reset) begin
    if (!reset) instr_q <= 32'd0;
    else        instr_q <= imem_mem[address_imem];
  end

  always_ff @(posedge dmem_clock) begin
    if (wren) dmem_mem[address_dmem] <= data;
    else      q_dmem <= dmem_mem[address_dmem];
  end

  assign opcode            = instr_q[31:27];
  assign rd                = instr_q[26:22];
  assign rs                = instr_q[21:17];
  assign rt                = instr_q[16:12];
  assign shamt             = instr_q[11:7];
  assign aluop             = instr_q[6:2];
  assign imm_ext           = {{15{instr_q[16]}}, instr_q[16:0]};
  assign unused_instr_bits = ^instr_q[1:0];

  assign is_r    = (opcode == OP_RTYPE);
  assign is_addi = (opcode == OP_ADDI);
  assign is_sw   = (opcode == OP_SW);
  assign is_lw   = (opcode == OP_LW);

  // Port B supplies rt for R-type and the store data (rd) otherwise.
  assign ctrl_readRegA = rs;
  assign ctrl_readRegB = is_r ? rt : rd;
  assign reg_a         = regs_q[ctrl_readRegA];
  assign reg_b         = regs_q[ctrl_readRegB];

  always_comb begin
    alu_b      = is_r ? reg_b : imm_ext;
    sum        = reg_a + alu_b;
    diff       = reg_a - alu_b;
    alu_result = sum;
    if (is_r) begin
      case (aluop)
        ALU_ADD: alu_result = sum;
        ALU_SUB: alu_result = diff;
        ALU_AND: alu_result = reg_a & reg_b;
        ALU_OR:  alu_result = reg_a | reg_b;
        ALU_SLL: alu_result = reg_a << shamt;
        ALU_SRA: alu_result = 32'($signed(reg_a) >>> shamt);
        default: alu_result = 32'd0;
      endcase
    end
  end

  assign address_dmem = sum[ADDR_WIDTH-1:0];
  assign data         = reg_b;
  assign wren         = is_sw;

`ifdef OVERFLOW_STATUS_EN
  logic       add_ovf, sub_ovf;
  logic [1:0] ovf_code;

  always_comb begin
    add_ovf  = (reg_a[31] == alu_b[31]) && (sum[31] != reg_a[31]);
    sub_ovf  = (reg_a[31] != alu_b[31]) && (diff[31] != reg_a[31]);
    ovf_code = 2'd0;
    if (is_r && (aluop == ALU_ADD) && add_ovf) ovf_code = 2'd1;
    if (is_addi && add_ovf)                    ovf_code = 2'd2;
    if (is_r && (aluop == ALU_SUB) && sub_ovf) ovf_code = 2'd3;
  end
`endif

  always_comb begin
    ctrl_writeEnable = is_r | is_addi | is_lw;
    ctrl_writeReg    = rd;
    data_writeReg    = is_lw ? q_dmem : alu_result;
`ifdef OVERFLOW_STATUS_EN
    if (ovf_code != 2'd0) begin
      ctrl_writeReg = 5'd30;
      data_writeReg = {30'd0, ovf_code};
    end
`endif
  end

  // r0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge regfile_clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
    end else if (ctrl_writeEnable && (ctrl_writeReg != 5'd0)) begin
      regs_q[ctrl_writeReg] <= data_writeReg;
    end
  end

endmodule

// File: tb/tb_skeleton_cpu.sv
// Directed bench for skeleton_cpu: programs are poked into the ROM and register state is compared against hand-computed values.
module tb_skeleton_cpu;

  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic imem_clock, dmem_clock, processor_clock, regfile_clock;

  int checks = 0;
  int errors = 0;
  logic [31:0] prog [$];

  skeleton_cpu #(
    .IMEM_INIT_FILE (""),
    .DMEM_INIT_FILE (""),
    .ADDR_WIDTH     (12)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .imem_clock      (imem_clock),
    .dmem_clock      (dmem_clock),
    .processor_clock (processor_clock),
    .regfile_clock   (regfile_clock)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] rtype(input int rd, input int rs, input int rt,
                                        input int shamt, input int aluop);
    return {5'b00000, 5'(rd), 5'(rs), 5'(rt), 5'(shamt), 5'(aluop), 2'b00};
  endfunction

  function automatic logic [31:0] itype(input logic [4:0] op, input int rd, input int rs, input int imm);
    return {op, 5'(rd), 5'(rs), 17'(imm)};
  endfunction

  task automatic load_and_start();
    reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 4096; i++) dut.imem_mem[i] = (i < prog.size()) ? prog[i] : 32'h0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic run_instrs(input int n);
    repeat (4 * n) @(negedge clock);
  endtask

  task automatic test_reset();
    int nonzero;
    logic exp_pat [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4096; i++) dut.imem_mem[i] = 32'h0;
    dut.dmem_mem[1] = 32'd1;
    dut.dmem_mem[2] = 32'd2;
    #2 reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (dut.address_imem !== 12'd0) begin errors++; $display("FAIL reset_pc: got %0d expected 0", dut.address_imem); end
    else $display("pass reset_pc = %0d", dut.address_imem);
    checks++;
    if (processor_clock !== 1'b0 || regfile_clock !== 1'b0) begin
      errors++; $display("FAIL reset_divclk: got %b/%b expected 0/0", processor_clock, regfile_clock);
    end else $display("pass reset_divclk low");
    checks++;
    if (dut.wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b expected 0", dut.wren); end
    else $display("pass reset_wren = 0");
    nonzero = 0;
    for (int r = 0; r < 32; r++) if (dut.regs_q[r] !== 32'd0) nonzero++;
    checks++;
    if (nonzero != 0) begin errors++; $display("FAIL reset_regs: got %0d nonzero registers expected 0", nonzero); end
    else $display("pass reset_regs all zero");
    checks++;
    if (imem_clock !== clock || dmem_clock !== clock) begin
      errors++; $display("FAIL mem_clocks: got %b/%b expected %b", imem_clock, dmem_clock, clock);
    end else $display("pass mem_clocks follow clock");
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      checks++;
      if (processor_clock !== exp_pat[k] || regfile_clock !== exp_pat[k]) begin
        errors++;
        $display("FAIL divider[%0d]: got %b/%b expected %b", k, processor_clock, regfile_clock, exp_pat[k]);
      end else $display("pass divider[%0d] = %b", k, processor_clock);
    end
    checks++;
    if (dut.address_imem !== 12'd2) begin errors++; $display("FAIL pc_after_8clk: got %0d expected 2", dut.address_imem); end
    else $display("pass pc_after_8clk = 2");
  endtask

  task automatic test_core();
    int          idx [10] = '{1, 2, 3, 4, 6, 7, 9, 10, 12, 30};
    logic [31:0] exp [10] = '{32'h0000FFFF, 32'h7FFF8000, 32'h7FFFFFFF, 32'h1, 32'h10000,
                              32'h80000000, 32'hFFFE, 32'h8000, 32'h7FFFFFFF, 32'h0};
    prog.delete();
    prog.push_back(itype(OP_ADDI, 1, 0, 65535));
    prog.push_back(rtype(2, 1, 0, 15, 4));
    prog.push_back(itype(OP_ADDI, 3, 2, 32767));
    prog.push_back(itype(OP_ADDI, 4, 0, 1));
    prog.push_back(rtype(6, 1, 4, 0, 0));
    prog.push_back(rtype(7, 4, 0, 31, 4));
    prog.push_back(rtype(9, 1, 4, 0, 1));
    prog.push_back(rtype(10, 1, 2, 0, 2));
    prog.push_back(rtype(12, 1, 2, 0, 3));
    load_and_start();
    run_instrs(10);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (dut.regs_q[idx[i]] !== exp[i]) begin
        errors++; $display("FAIL core_r%0d: got %h expected %h", idx[i], dut.regs_q[idx[i]], exp[i]);
      end else $display("pass core_r%0d = %h", idx[i], exp[i]);
    end
  endtask

  task automatic test_back_to_back();
    int          idx [14] = '{20, 21, 22, 23, 24, 25, 26, 16, 15, 12, 11, 14, 13, 17};
    logic [31:0] exp [14] = '{32'd2, 32'd3, 32'd1, 32'd1, 32'd3, 32'd2, 32'd1,
                              32'hFFFFFFFF, 32'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd9, 32'h80000000};
    prog.delete();
    prog.push_back(itype(OP_ADDI, 4, 0, 1));
    prog.push_back(itype(OP_ADDI, 20, 0, 2));
    prog.push_back(rtype(21, 4, 20, 0, 0));
    prog.push_back(rtype(22, 20, 4, 0, 1));
    prog.push_back(rtype(23, 22, 21, 0, 2));
    prog.push_back(rtype(24, 20, 23, 0, 3));
    prog.push_back(rtype(25, 23, 0, 1, 4));
    prog.push_back(rtype(26, 25, 0, 1, 5));
    prog.push_back(rtype(17, 4, 0, 31, 4));
    prog.push_back(rtype(16, 17, 0, 31, 5));
    prog.push_back(rtype(15, 20, 0, 0, 4));
    prog.push_back(rtype(12, 17, 0, 0, 5));
    prog.push_back(itype(OP_ADDI, 11, 0, -1));
    prog.push_back(itype(OP_ADDI, 14, 0, 7));
    prog.push_back(rtype(14, 20, 4, 0, 6));
    prog.push_back(itype(OP_ADDI, 13, 0, 9));
    prog.push_back(itype(5'b11111, 13, 0, 5));
    load_and_start();
    run_instrs(18);
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (dut.regs_q[idx[i]] !== exp[i]) begin
        errors++; $display("FAIL b2b_r%0d: got %h expected %h", idx[i], dut.regs_q[idx[i]], exp[i]);
      end else $display("pass b2b_r%0d = %h", idx[i], exp[i]);
    end
  endtask

  task automatic test_memory();
    int wren_cnt = 0;
    int          idx [3] = '{28, 29, 19};
    logic [31:0] exp [3] = '{32'd1, 32'd2, 32'd65535};
    prog.delete();
    prog.push_back(itype(OP_ADDI, 1, 0, 65535));
    prog.push_back(itype(OP_ADDI, 27, 0, 456));
    prog.push_back(itype(OP_SW, 1, 27, 0));
    prog.push_back(itype(OP_LW, 28, 0, 1));
    prog.push_back(itype(OP_LW, 29, 0, 2));
    prog.push_back(itype(OP_LW, 19, 27, 0));
    load_and_start();
    for (int c = 0; c < 32; c++) begin
      @(negedge clock);
      if (dut.wren === 1'b1) wren_cnt++;
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dut.regs_q[idx[i]] !== exp[i]) begin
        errors++; $display("FAIL mem_r%0d: got %h expected %h", idx[i], dut.regs_q[idx[i]], exp[i]);
      end else $display("pass mem_r%0d = %h", idx[i], exp[i]);
    end
    checks++;
    if (dut.dmem_mem[456] !== 32'h0000FFFF) begin
      errors++; $display("FAIL mem_store456: got %h expected 0000ffff", dut.dmem_mem[456]);
    end else $display("pass mem_store456 = 0000ffff");
    checks++;
    if (wren_cnt != 4) begin errors++; $display("FAIL wren_width: got %0d clocks expected 4", wren_cnt); end
    else $display("pass wren_width = 4 clocks");
  endtask

  task automatic test_overflow();
    logic [31:0] exp_r5, exp_r31, exp_r8, exp_add30, exp_addi30, exp_sub30;
`ifdef OVERFLOW_STATUS_EN
    exp_r5 = 32'd77; exp_r31 = 32'd0; exp_r8 = 32'd0;
    exp_add30 = 32'd1; exp_addi30 = 32'd2; exp_sub30 = 32'd3;
`else
    exp_r5 = 32'h80000000; exp_r31 = 32'h80000000; exp_r8 = 32'h7FFFFFFF;
    exp_add30 = 32'd0; exp_addi30 = 32'd0; exp_sub30 = 32'd0;
`endif
    prog.delete();
    prog.push_back(itype(OP_ADDI, 1, 0, 65535));
    prog.push_back(rtype(2, 1, 0, 15, 4));
    prog.push_back(itype(OP_ADDI, 3, 2, 32767));
    prog.push_back(itype(OP_ADDI, 4, 0, 1));
    prog.push_back(itype(OP_ADDI, 5, 0, 77));
    prog.push_back(rtype(7, 4, 0, 31, 4));
    prog.push_back(rtype(5, 3, 4, 0, 0));
    prog.push_back(itype(OP_ADDI, 31, 3, 1));
    prog.push_back(rtype(8, 7, 4, 0, 1));
    load_and_start();
    run_instrs(7);
    checks++;
    if (dut.regs_q[5] !== exp_r5) begin errors++; $display("FAIL ovf_add_r5: got %h expected %h", dut.regs_q[5], exp_r5); end
    else $display("pass ovf_add_r5 = %h", exp_r5);
    checks++;
    if (dut.regs_q[30] !== exp_add30) begin errors++; $display("FAIL ovf_add_r30: got %h expected %h", dut.regs_q[30], exp_add30); end
    else $display("pass ovf_add_r30 = %h", exp_add30);
    run_instrs(1);
    checks++;
    if (dut.regs_q[31] !== exp_r31) begin errors++; $display("FAIL ovf_addi_r31: got %h expected %h", dut.regs_q[31], exp_r31); end
    else $display("pass ovf_addi_r31 = %h", exp_r31);
    checks++;
    if (dut.regs_q[30] !== exp_addi30) begin errors++; $display("FAIL ovf_addi_r30: got %h expected %h", dut.regs_q[30], exp_addi30); end
    else $display("pass ovf_addi_r30 = %h", exp_addi30);
    run_instrs(1);
    checks++;
    if (dut.regs_q[8] !== exp_r8) begin errors++; $display("FAIL ovf_sub_r8: got %h expected %h", dut.regs_q[8], exp_r8); end
    else $display("pass ovf_sub_r8 = %h", exp_r8);
    checks++;
    if (dut.regs_q[30] !== exp_sub30) begin errors++; $display("FAIL ovf_sub_r30: got %h expected %h", dut.regs_q[30], exp_sub30); end
    else $display("pass ovf_sub_r30 = %h", exp_sub30);
  endtask

  task automatic test_r0_and_reset();
    int nonzero;
    prog.delete();
    prog.push_back(itype(OP_ADDI, 0, 0, 5));
    prog.push_back(itype(OP_ADDI, 1, 0, 3));
    prog.push_back(rtype(2, 0, 1, 0, 0));
    prog.push_back(itype(OP_ADDI, 3, 0, 9));
    load_and_start();
    run_instrs(3);
    checks++;
    if (dut.regs_q[0] !== 32'd0) begin errors++; $display("FAIL r0_write: got %h expected 0", dut.regs_q[0]); end
    else $display("pass r0_write ignored");
    checks++;
    if (dut.regs_q[2] !== 32'd3) begin errors++; $display("FAIL r0_read: got %h expected 3", dut.regs_q[2]); end
    else $display("pass r0_read r2 = 3");
    repeat (6) @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if (dut.address_imem !== 12'd0) begin errors++; $display("FAIL midreset_pc: got %0d expected 0", dut.address_imem); end
    else $display("pass midreset_pc = 0");
    nonzero = 0;
    for (int r = 0; r < 32; r++) if (dut.regs_q[r] !== 32'd0) nonzero++;
    checks++;
    if (nonzero != 0) begin errors++; $display("FAIL midreset_regs: got %0d nonzero expected 0", nonzero); end
    else $display("pass midreset_regs all zero");
    checks++;
    if (processor_clock !== 1'b0) begin errors++; $display("FAIL midreset_divclk: got %b expected 0", processor_clock); end
    else $display("pass midreset_divclk low");
    repeat (3) @(negedge clock);
    reset = 1'b1;
    run_instrs(2);
    checks++;
    if (dut.regs_q[1] !== 32'd3 || dut.regs_q[3] !== 32'd0) begin
      errors++; $display("FAIL restart_regs: got r1=%h r3=%h expected r1=3 r3=0", dut.regs_q[1], dut.regs_q[3]);
    end else $display("pass restart_regs r1=3 r3=0");
    checks++;
    if (dut.address_imem !== 12'd2) begin errors++; $display("FAIL restart_pc: got %0d expected 2", dut.address_imem); end
    else $display("pass restart_pc = 2");
  endtask

  task automatic test_pc_wrap();
    prog.delete();
    for (int i = 0; i < 4096; i++) prog.push_back(itype(OP_ADDI, 1, 1, 1));
    load_and_start();
    run_instrs(4097);
    checks++;
    if (dut.address_imem !== 12'd1) begin errors++; $display("FAIL pc_wrap: got %0d expected 1", dut.address_imem); end
    else $display("pass pc_wrap = 1");
    checks++;
    if (dut.regs_q[1] !== 32'd4097) begin errors++; $display("FAIL wrap_count: got %0d expected 4097", dut.regs_q[1]); end
    else $display("pass wrap_count = 4097");
  endtask

  initial begin
    test_reset();
    test_core();
    test_back_to_back();
    test_memory();
    test_overflow();
    test_r0_and_reset();
    test_pc_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
